// File: rtl/dmx_pry_reg_if.sv
// dmx_pry_reg_if: handshake bundle for the priority demux register
interface dmx_pry_reg_if #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 32,
  parameter int  CNT_W = 16
);
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] in_pry;
  DAT_T             in_dat;
  logic [WIDTH-1:0] out_vld;
  logic [WIDTH-1:0] out_rdy;
  DAT_T             out_dat;
  logic [CNT_W-1:0] drp_cnt;
  modport master (output in_vld, in_pry, in_dat, out_rdy,
                  input  in_rdy, out_vld, out_dat, drp_cnt);
  modport slave  (input  in_vld, in_pry, in_dat, out_rdy,
                  output in_rdy, out_vld, out_dat, drp_cnt);
endinterface

// File: rtl/dmx_pry_reg.sv
// dmx_pry_reg: registered priority demux routing each word to its lowest requested lane
module dmx_pry_reg #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 32,
  parameter int  CNT_W = 16
) (
  input logic          clk,
  input logic          rst_n,
  dmx_pry_reg_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] vld_q, sel;
  DAT_T             dat_q;
  logic [CNT_W-1:0] cnt_q;
  logic             drain, rdy, acc, load, drop;
  // lowest set bit of the request isolated by two's complement
  assign sel   = bus.in_pry & (-bus.in_pry);
  assign drain = |(vld_q & bus.out_rdy);
  assign rdy   = (state == EMPTY) | drain;
  assign acc   = bus.in_vld & rdy;
  assign load  = acc & (|bus.in_pry);
  assign drop  = acc & ~(|bus.in_pry);
  // load wins over drain; a drain alone empties the stage
  always_comb state_nxt = load ? FULL : drain ? EMPTY : state;
  // output stage and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      vld_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      vld_q <= load ? sel : drain ? '0 : vld_q;
      dat_q <= load ? bus.in_dat : dat_q;
      if (drop && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign bus.in_rdy  = rdy;
  assign bus.out_vld = vld_q;
  assign bus.out_dat = dat_q;
  assign bus.drp_cnt = cnt_q;
endmodule

// File: tb/tb_dmx_pry_reg.sv
// tb_dmx_pry_reg: scoreboard bench for the priority demux register
module tb_dmx_pry_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dmx_pry_reg_if #(.DAT_T(logic [7:0]), .WIDTH(32), .CNT_W(16)) bus ();
  dmx_pry_reg_if #(.DAT_T(logic [7:0]), .WIDTH(2),  .CNT_W(2))  b2 ();
  dmx_pry_reg #(.DAT_T(logic [7:0]), .WIDTH(32), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  dmx_pry_reg #(.DAT_T(logic [7:0]), .WIDTH(2),  .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  typedef struct {int lane; logic [7:0] dat;} exp_t;
  exp_t q[$];
  logic [15:0] exp_cnt = '0;
  int n_tot = 0;
  int n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic int lowest(input logic [31:0] p);
    for (int i = 0; i < 32; i++) if (p[i]) return i;
    return -1;
  endfunction
  task automatic tick();
    logic rdy_m, drn;
    @(negedge clk);
    rdy_m = (q.size() == 0) || bus.out_rdy[q[0].lane];
    drn = (q.size() != 0) && bus.out_rdy[q[0].lane];
    chk("occupancy", 64'(|bus.out_vld), 64'(q.size() != 0));
    chk("in_rdy", 64'(bus.in_rdy), 64'(rdy_m));
    chk("drp_cnt", 64'(bus.drp_cnt), 64'(exp_cnt));
    if (q.size() != 0) begin
      chk("lane", 64'(bus.out_vld), 64'(1) << q[0].lane);
      chk("out_dat", 64'(bus.out_dat), 64'(q[0].dat));
    end
    if (drn) void'(q.pop_front());
    if (bus.in_vld && rdy_m) begin
      if (bus.in_pry != 0) q.push_back('{lowest(bus.in_pry), bus.in_dat});
      else if (exp_cnt != 16'hFFFF) exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_vld = 0; bus.in_pry = '0; bus.in_dat = '0; bus.out_rdy = '1;
    b2.in_vld = 0;  b2.in_pry = '0;  b2.in_dat = '0;  b2.out_rdy = '1;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    tick();
    // single transfer to lane 4
    bus.in_vld = 1; bus.in_pry = 32'h0000_0050; bus.in_dat = 8'hA5;
    tick();
    bus.in_vld = 0; bus.in_pry = '1; bus.in_dat = 8'hFF;
    chk("single_vld", 64'(bus.out_vld), 64'h10);
    chk("single_dat", 64'(bus.out_dat), 64'hA5);
    tick();
    chk("single_empty", 64'(bus.out_vld), 64'h0);
    // stall on lane 4 while lane 5 is ready, with a pending word waiting
    bus.in_vld = 1; bus.in_pry = 32'h0000_0030; bus.in_dat = 8'h5A;
    tick();
    bus.out_rdy = 32'hFFFF_FFEF; bus.in_pry = 32'h0000_0001; bus.in_dat = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rdy", 64'(bus.in_rdy), 64'h0);
      chk("stall_vld", 64'(bus.out_vld), 64'h10);
      chk("stall_dat", 64'(bus.out_dat), 64'h5A);
    end
    bus.out_rdy = '1;
    tick();
    chk("reload_vld", 64'(bus.out_vld), 64'h1);
    chk("reload_dat", 64'(bus.out_dat), 64'h3C);
    // streaming to lanes 0..7
    for (int i = 0; i < 8; i++) begin
      bus.in_pry = 32'h1 << i; bus.in_dat = 8'(i * 17 + 1);
      tick();
      chk("stream_rdy", 64'(bus.in_rdy), 64'h1);
      chk("stream_vld", 64'(bus.out_vld), 64'(1) << i);
    end
    bus.in_vld = 0;
    tick();
    tick();
    // three drops
    bus.in_vld = 1; bus.in_pry = '0;
    for (int i = 0; i < 3; i++) tick();
    bus.in_vld = 0;
    tick();
    chk("drop_cnt", 64'(bus.drp_cnt), 64'd3);
    chk("drop_vld", 64'(bus.out_vld), 64'h0);
    // narrow counter saturates
    b2.in_vld = 1;
    for (int i = 0; i < 5; i++) tick();
    b2.in_vld = 0;
    tick();
    chk("sat_cnt", 64'(b2.drp_cnt), 64'd3);
    chk("sat_vld", 64'(b2.out_vld), 64'h0);
    // asynchronous reset while holding lane 31
    bus.in_vld = 1; bus.in_pry = 32'h8000_0000; bus.in_dat = 8'hC3; bus.out_rdy = '0;
    tick();
    bus.in_vld = 0;
    tick();
    chk("pre_rst_vld", 64'(bus.out_vld), 64'h8000_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", 64'(bus.out_vld), 64'h0);
    chk("rst_dat", 64'(bus.out_dat), 64'h0);
    chk("rst_cnt", 64'(bus.drp_cnt), 64'h0);
    chk("rst_rdy", 64'(bus.in_rdy), 64'h1);
    q.delete();
    exp_cnt = '0;
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_vld", 64'(bus.out_vld), 64'h0);
    // constrained random traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 3);
      bus.in_vld = ($urandom_range(0, 3) != 0);
      bus.in_pry = (r == 0) ? 32'h0 : (r == 1) ? (32'h1 << $urandom_range(0, 31)) : 32'($urandom);
      bus.in_dat = 8'($urandom);
      bus.out_rdy = 32'($urandom) | 32'($urandom);
      tick();
    end
    bus.in_vld = 0; bus.out_rdy = '1;
    tick();
    tick();
    chk("final_empty", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
